// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and pending-write scoreboard for the RVS192 register file.
// Three result producers (ALU, LSU, MDU) share one write port. A round-robin
// arbiter picks one of them, and the winning result is registered onto
// data_wb/rd/reg_wen. The scoreboard tracks registers with writes still
// outstanding, so that decode can stall on RAW and WAW hazards.
module regfile_wb_arbiter #(
  parameter int DATA_LENGTH         = 32,
  parameter int REGISTER_FILE_DEPTH = 32
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   alu_valid,
  input  logic                                   lsu_valid,
  input  logic                                   mdu_valid,
  input  logic [$clog2(REGISTER_FILE_DEPTH)-1:0] alu_rd,
  input  logic [$clog2(REGISTER_FILE_DEPTH)-1:0] lsu_rd,
  input  logic [$clog2(REGISTER_FILE_DEPTH)-1:0] mdu_rd,
  input  logic [DATA_LENGTH-1:0]                 alu_data,
  input  logic [DATA_LENGTH-1:0]                 lsu_data,
  input  logic [DATA_LENGTH-1:0]                 mdu_data,
  output logic                                   alu_ready,
  output logic                                   lsu_ready,
  output logic                                   mdu_ready,
  input  logic                                   iss_valid,
  input  logic [$clog2(REGISTER_FILE_DEPTH)-1:0] iss_rd,
  output logic                                   iss_ready,
  input  logic [$clog2(REGISTER_FILE_DEPTH)-1:0] rs1,
  input  logic [$clog2(REGISTER_FILE_DEPTH)-1:0] rs2,
  output logic                                   rs1_busy,
  output logic                                   rs2_busy,
  output logic [DATA_LENGTH-1:0]                 data_wb,
  output logic [$clog2(REGISTER_FILE_DEPTH)-1:0] rd,
  output logic                                   reg_wen
);

  localparam int IdxW = $clog2(REGISTER_FILE_DEPTH);

  localparam logic [1:0] REQ_ALU = 2'd0;
  localparam logic [1:0] REQ_LSU = 2'd1;
  localparam logic [1:0] REQ_MDU = 2'd2;

  logic [1:0]                     last_q, last_d;
  logic [2:0]                     valid_vec;
  logic [2:0]                     grant;
  logic [1:0]                     grant_idx;
  logic                           xfer;
  logic [IdxW-1:0]                sel_rd;
  logic [DATA_LENGTH-1:0]         sel_data;
  logic                           wen_q, wen_d;
  logic [IdxW-1:0]                rd_q, rd_d;
  logic [DATA_LENGTH-1:0]         data_q, data_d;
  logic [REGISTER_FILE_DEPTH-1:0] pending_q, pending_d;

  assign valid_vec = {mdu_valid, lsu_valid, alu_valid};

  // Round-robin pick: search starts one past the last winner and wraps; the grant is gated off during reset
  always_comb begin
    grant     = 3'b000;
    grant_idx = REQ_ALU;
    case (last_q)
      REQ_ALU: begin
        if (valid_vec[1])      begin grant = 3'b010; grant_idx = REQ_LSU; end
        else if (valid_vec[2]) begin grant = 3'b100; grant_idx = REQ_MDU; end
        else if (valid_vec[0]) begin grant = 3'b001; grant_idx = REQ_ALU; end
      end
      REQ_LSU: begin
        if (valid_vec[2])      begin grant = 3'b100; grant_idx = REQ_MDU; end
        else if (valid_vec[0]) begin grant = 3'b001; grant_idx = REQ_ALU; end
        else if (valid_vec[1]) begin grant = 3'b010; grant_idx = REQ_LSU; end
      end
      default: begin
        if (valid_vec[0])      begin grant = 3'b001; grant_idx = REQ_ALU; end
        else if (valid_vec[1]) begin grant = 3'b010; grant_idx = REQ_LSU; end
        else if (valid_vec[2]) begin grant = 3'b100; grant_idx = REQ_MDU; end
      end
    endcase
    if (!rst_n) begin
      grant = 3'b000;
    end
  end

  assign alu_ready = grant[0];
  assign lsu_ready = grant[1];
  assign mdu_ready = grant[2];
  assign xfer      = |grant;

  // Steer the winning requester's index and data towards the write-back register
  always_comb begin
    sel_rd   = alu_rd;
    sel_data = alu_data;
    case (grant_idx)
      REQ_LSU: begin sel_rd = lsu_rd; sel_data = lsu_data; end
      REQ_MDU: begin sel_rd = mdu_rd; sel_data = mdu_data; end
      default: begin sel_rd = alu_rd; sel_data = alu_data; end
    endcase
  end

  // Next state of the pointer and the write-back register; writes to x0 are accepted but never enabled
  always_comb begin
    last_d = last_q;
    wen_d  = 1'b0;
    rd_d   = rd_q;
    data_d = data_q;
    if (xfer) begin
      last_d = grant_idx;
      wen_d  = (sel_rd != '0);
      rd_d   = sel_rd;
      data_d = sel_data;
    end
  end

  // Scoreboard next state: clear on the registered write, then set on issue so a set wins a collision
  always_comb begin
    pending_d = pending_q;
    if (wen_q) begin
      pending_d[rd_q] = 1'b0;
    end
    if (iss_valid && iss_ready && (iss_rd != '0)) begin
      pending_d[iss_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // State registers; reset drops any in-flight write-back and makes the ALU the first winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= REQ_MDU;
      wen_q     <= 1'b0;
      rd_q      <= '0;
      data_q    <= '0;
      pending_q <= '0;
    end else begin
      last_q    <= last_d;
      wen_q     <= wen_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      pending_q <= pending_d;
    end
  end

  assign iss_ready = ~pending_q[iss_rd];
  assign rs1_busy  = pending_q[rs1];
  assign rs2_busy  = pending_q[rs2];
  assign data_wb   = data_q;
  assign rd        = rd_q;
  assign reg_wen   = wen_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter. Inputs change 1ns after each
// rising edge, and outputs are sampled 1ns later, well away from either edge.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_valid, lsu_valid, mdu_valid;
  logic [4:0]  alu_rd, lsu_rd, mdu_rd;
  logic [31:0] alu_data, lsu_data, mdu_data;
  logic        alu_ready, lsu_ready, mdu_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  rs1, rs2;
  logic        rs1_busy, rs2_busy;
  logic [31:0] data_wb;
  logic [4:0]  rd;
  logic        reg_wen;
  logic [2:0]  readyVec;

  int checks;
  int failures;

  regfile_wb_arbiter #(
    .DATA_LENGTH(32),
    .REGISTER_FILE_DEPTH(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .alu_valid(alu_valid),
    .lsu_valid(lsu_valid),
    .mdu_valid(mdu_valid),
    .alu_rd(alu_rd),
    .lsu_rd(lsu_rd),
    .mdu_rd(mdu_rd),
    .alu_data(alu_data),
    .lsu_data(lsu_data),
    .mdu_data(mdu_data),
    .alu_ready(alu_ready),
    .lsu_ready(lsu_ready),
    .mdu_ready(mdu_ready),
    .iss_valid(iss_valid),
    .iss_rd(iss_rd),
    .iss_ready(iss_ready),
    .rs1(rs1),
    .rs2(rs2),
    .rs1_busy(rs1_busy),
    .rs2_busy(rs2_busy),
    .data_wb(data_wb),
    .rd(rd),
    .reg_wen(reg_wen)
  );

  assign readyVec = {mdu_ready, lsu_ready, alu_ready};

  // 10ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] v,
                               input logic [4:0] aRd, input logic [31:0] aData,
                               input logic [4:0] lRd, input logic [31:0] lData,
                               input logic [4:0] mRd, input logic [31:0] mData);
    alu_valid = v[0];
    lsu_valid = v[1];
    mdu_valid = v[2];
    alu_rd    = aRd;
    alu_data  = aData;
    lsu_rd    = lRd;
    lsu_data  = lData;
    mdu_rd    = mRd;
    mdu_data  = mData;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [2:0] expReady [6];
    logic [4:0] expRd [6];
    expReady = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    expRd    = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
    checks   = 0;
    failures = 0;

    rst_n     = 1'b1;
    iss_valid = 1'b0;
    iss_rd    = 5'd5;
    rs1       = 5'd0;
    rs2       = 5'd0;
    applyStimulus(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    #1 rst_n = 1'b0;
    applyStimulus(3'b111, 5'd1, 32'h11, 5'd2, 32'h22, 5'd3, 32'h33);

    // Reset state: readies gated off even with every requester valid
    nextCycle();
    settle();
    checkOutput("reset_ready", 32'(readyVec), 32'd0);
    checkOutput("reset_wen", 32'(reg_wen), 32'd0);
    checkOutput("reset_rd", 32'(rd), 32'd0);
    checkOutput("reset_data", data_wb, 32'd0);
    checkOutput("reset_iss_ready", 32'(iss_ready), 32'd1);
    checkOutput("reset_rs1_busy", 32'(rs1_busy), 32'd0);

    // Round-robin with all three valid, reset released in the first step
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      if (i == 0) rst_n = 1'b1;
      settle();
      checkOutput("rr_ready", 32'(readyVec), 32'(expReady[i]));
      checkOutput("rr_wen", 32'(reg_wen), (i == 0) ? 32'd0 : 32'd1);
      if (i > 0) begin
        checkOutput("rr_rd", 32'(rd), 32'(expRd[i-1]));
        checkOutput("rr_data", data_wb, 32'h11 * 32'(expRd[i-1]));
      end
    end

    // Drain the last MDU result, then check the write-back register holds
    nextCycle();
    applyStimulus(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    settle();
    checkOutput("drain_ready", 32'(readyVec), 32'd0);
    checkOutput("drain_wen", 32'(reg_wen), 32'd1);
    checkOutput("drain_rd", 32'(rd), 32'd3);
    checkOutput("drain_data", data_wb, 32'h33);
    nextCycle();
    settle();
    checkOutput("idle_wen", 32'(reg_wen), 32'd0);
    checkOutput("idle_rd_hold", 32'(rd), 32'd3);
    checkOutput("idle_data_hold", data_wb, 32'h33);

    // LSU streaming alone: granted every cycle
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      applyStimulus(3'b010, 5'd0, 32'h0, 5'(5 + i), 32'hA0 + 32'(i), 5'd0, 32'h0);
      settle();
      checkOutput("stream_ready", 32'(readyVec), 32'b010);
      if (i > 0) begin
        checkOutput("stream_wen", 32'(reg_wen), 32'd1);
        checkOutput("stream_rd", 32'(rd), 32'd4 + 32'(i));
        checkOutput("stream_data", data_wb, 32'h9F + 32'(i));
      end
    end
    nextCycle();
    applyStimulus(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    settle();
    checkOutput("stream_last_wen", 32'(reg_wen), 32'd1);
    checkOutput("stream_last_rd", 32'(rd), 32'd8);
    checkOutput("stream_last_data", data_wb, 32'hA3);

    // RAW: issue x7, MDU writes x7 three cycles later
    nextCycle();
    iss_valid = 1'b1;
    iss_rd    = 5'd7;
    rs1       = 5'd7;
    settle();
    checkOutput("raw_iss_ready", 32'(iss_ready), 32'd1);
    checkOutput("raw_busy_c0", 32'(rs1_busy), 32'd0);
    nextCycle();
    iss_valid = 1'b0;
    settle();
    checkOutput("raw_busy_c1", 32'(rs1_busy), 32'd1);
    checkOutput("raw_waw_c1", 32'(iss_ready), 32'd0);
    nextCycle();
    settle();
    checkOutput("raw_busy_c2", 32'(rs1_busy), 32'd1);
    nextCycle();
    applyStimulus(3'b100, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 32'h77);
    settle();
    checkOutput("raw_mdu_ready", 32'(readyVec), 32'b100);
    checkOutput("raw_busy_c3", 32'(rs1_busy), 32'd1);
    nextCycle();
    applyStimulus(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    settle();
    checkOutput("raw_wen_c4", 32'(reg_wen), 32'd1);
    checkOutput("raw_rd_c4", 32'(rd), 32'd7);
    checkOutput("raw_data_c4", data_wb, 32'h77);
    checkOutput("raw_busy_c4", 32'(rs1_busy), 32'd1);
    nextCycle();
    settle();
    checkOutput("raw_wen_c5", 32'(reg_wen), 32'd0);
    checkOutput("raw_busy_c5", 32'(rs1_busy), 32'd0);
    checkOutput("raw_iss_ready_c5", 32'(iss_ready), 32'd1);

    // WAW on x9 and the x0 special cases
    nextCycle();
    iss_valid = 1'b1;
    iss_rd    = 5'd9;
    settle();
    checkOutput("waw_issue_x9", 32'(iss_ready), 32'd1);
    nextCycle();
    iss_valid = 1'b0;
    rs2       = 5'd9;
    settle();
    checkOutput("waw_iss_ready", 32'(iss_ready), 32'd0);
    checkOutput("waw_rs2_busy", 32'(rs2_busy), 32'd1);
    nextCycle();
    iss_valid = 1'b1;
    iss_rd    = 5'd0;
    rs1       = 5'd0;
    settle();
    checkOutput("x0_iss_ready", 32'(iss_ready), 32'd1);
    nextCycle();
    iss_valid = 1'b0;
    applyStimulus(3'b001, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0, 5'd0, 32'h0);
    settle();
    checkOutput("x0_rs1_busy", 32'(rs1_busy), 32'd0);
    checkOutput("x0_alu_ready", 32'(readyVec), 32'b001);
    nextCycle();
    applyStimulus(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    settle();
    checkOutput("x0_wen", 32'(reg_wen), 32'd0);
    checkOutput("x0_rd", 32'(rd), 32'd0);
    checkOutput("x0_x9_still_busy", 32'(rs2_busy), 32'd1);

    // Set/clear collision on x4: issue stalls while the clear is in flight
    nextCycle();
    iss_valid = 1'b1;
    iss_rd    = 5'd4;
    rs2       = 5'd4;
    settle();
    checkOutput("sc_issue_x4", 32'(iss_ready), 32'd1);
    checkOutput("sc_busy_c0", 32'(rs2_busy), 32'd0);
    nextCycle();
    iss_valid = 1'b0;
    applyStimulus(3'b001, 5'd4, 32'h44, 5'd0, 32'h0, 5'd0, 32'h0);
    settle();
    checkOutput("sc_alu_ready", 32'(readyVec), 32'b001);
    checkOutput("sc_busy_c1", 32'(rs2_busy), 32'd1);
    nextCycle();
    applyStimulus(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    iss_valid = 1'b1;
    settle();
    checkOutput("sc_wen_c2", 32'(reg_wen), 32'd1);
    checkOutput("sc_rd_c2", 32'(rd), 32'd4);
    checkOutput("sc_stall_c2", 32'(iss_ready), 32'd0);
    nextCycle();
    settle();
    checkOutput("sc_wen_c3", 32'(reg_wen), 32'd0);
    checkOutput("sc_retry_c3", 32'(iss_ready), 32'd1);
    checkOutput("sc_busy_c3", 32'(rs2_busy), 32'd0);
    nextCycle();
    iss_valid = 1'b0;
    settle();
    checkOutput("sc_busy_c4", 32'(rs2_busy), 32'd1);
    checkOutput("sc_iss_ready_c4", 32'(iss_ready), 32'd0);

    // Reset in the middle of a write-back, then ALU wins first after release
    nextCycle();
    applyStimulus(3'b111, 5'd1, 32'h11, 5'd10, 32'hBEEF, 5'd3, 32'h33);
    rs2 = 5'd9;
    settle();
    checkOutput("mr_lsu_ready", 32'(readyVec), 32'b010);
    nextCycle();
    applyStimulus(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    settle();
    checkOutput("mr_wen_before", 32'(reg_wen), 32'd1);
    checkOutput("mr_rd_before", 32'(rd), 32'd10);
    checkOutput("mr_busy_before", 32'(rs2_busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mr_wen_async", 32'(reg_wen), 32'd0);
    checkOutput("mr_rd_async", 32'(rd), 32'd0);
    checkOutput("mr_data_async", data_wb, 32'd0);
    checkOutput("mr_busy_cleared", 32'(rs2_busy), 32'd0);
    checkOutput("mr_iss_ready", 32'(iss_ready), 32'd1);
    nextCycle();
    applyStimulus(3'b111, 5'd1, 32'h11, 5'd10, 32'hBEEF, 5'd3, 32'h33);
    settle();
    checkOutput("mr_ready_gated", 32'(readyVec), 32'd0);
    nextCycle();
    rst_n = 1'b1;
    settle();
    checkOutput("mr_alu_first", 32'(readyVec), 32'b001);
    nextCycle();
    applyStimulus(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    settle();
    checkOutput("mr_post_wen", 32'(reg_wen), 32'd1);
    checkOutput("mr_post_rd", 32'(rd), 32'd1);
    checkOutput("mr_post_data", data_wb, 32'h11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the RVS192 register file. It shares the single register-file write port between three result producers: ALU, load/store unit (LSU) and multiply/divide unit (MDU). Arbitration is round-robin with a valid/ready handshake, and the winning result is registered into the register file's `data_wb`/`rd`/`reg_wen` inputs. It also keeps a 32-entry pending-write scoreboard that decode uses to stall on RAW hazards (an operand register still has a write outstanding) and WAW hazards (a destination register already has a write outstanding).

## Interface
- `DATA_LENGTH`, 32, width of result data and of `data_wb`.
- `REGISTER_FILE_DEPTH`, 32, number of architectural registers (5-bit index).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset is asynchronous and active-low.
- `alu_valid`, `lsu_valid`, `mdu_valid` input 1 each: the requester holds a result.
- `alu_rd`, `lsu_rd`, `mdu_rd` input 5 each: destination register index.
- `alu_data`, `lsu_data`, `mdu_data` input DATA_LENGTH each: result value.
- `alu_ready`, `lsu_ready`, `mdu_ready` output 1 each: the grant. The result is accepted in a cycle where valid=1 and ready=1.
- `iss_valid` input 1: decode issues an instruction that writes `iss_rd`.
- `iss_rd` input 5: destination register of the issuing instruction.
- `iss_ready` output 1: issue is allowed (no WAW hazard).
- `rs1`, `rs2` input 5: source registers being decoded.
- `rs1_busy`, `rs2_busy` output 1: the source register has a pending write.
- `data_wb` output DATA_LENGTH: write data to the register file.
- `rd` output 5: write index to the register file.
- `reg_wen` output 1: write enable to the register file.

## Operation
- **Arbitration (combinational).**
  - Requester order is ALU=0, LSU=1, MDU=2.
  - A 2-bit pointer `last` holds the most recent grant. Priority starts at (`last`+1) mod 3 and wraps.
  - Exactly one ready is asserted per cycle, only to a requester that has valid=1. If no requester is valid, all readies are 0.
  - `ready` must not depend on `ready`; no combinational loops.
- **Pointer update.** On an accepted transfer, `last` ← index of the granted requester. With no transfer, `last` holds.
- **Write-back register.**
  - On an accepted transfer, the next edge loads `data_wb` ← data, `rd` ← rd, and `reg_wen` ← (rd≠0).
  - With no transfer, `reg_wen` ← 0 and `data_wb`/`rd` hold their previous values.
  - A transfer with rd=0 is accepted and its data is discarded (`reg_wen` stays 0).
- **Scoreboard.**
  - `pending[31:0]`; bit 0 is hard-wired to 0.
  - Set: when `iss_valid`=1, `iss_ready`=1 and `iss_rd`≠0, `pending[iss_rd]` ← 1.
  - Clear: when `reg_wen`=1 (the registered output), `pending[rd]` ← 0 at that edge. The clear therefore lands at the same edge where the register file captures the data.
  - Set and clear on the same index at the same edge: set wins.
  - A clear of a non-pending bit has no effect.
- **Hazard outputs (combinational from `pending`).**
  - `iss_ready` = ~`pending[iss_rd]`.
  - `rs1_busy` = `pending[rs1]`; `rs2_busy` = `pending[rs2]`.
  - Register x0 is never busy.
- The block does not track which unit owns a pending bit. Any requester's write to that index clears it.

## Timing
- **Reset (`rst_n`=0, asynchronous).**
  - `reg_wen`=0, `rd`=0, `data_wb`=0, `pending`=0.
  - `last`=2, so ALU has first priority after reset.
  - All readies are forced to 0 while `rst_n`=0. `iss_ready` reads 1 and the busy outputs read 0.
- **Latency.**
  - Cycle N: the transfer is accepted.
  - Cycle N+1: `reg_wen`/`rd`/`data_wb` are valid for one cycle.
  - The register file captures the data at the end of N+1, and the pending bit clears at that same edge.
  - The busy output is still 1 during N+1 and reads 0 from cycle N+2.
- **Throughput.** One write-back per cycle, sustained. Back-to-back grants to the same requester are allowed only when it is the sole valid requester.
- **Requester rules.** Valid, rd and data must stay stable until accepted. Valid may fall only after a transfer.
- **Issue rules.** Issue is accepted in the same cycle as `iss_ready`. An issue to a register being cleared in the same cycle sees `iss_ready`=0; decode retries the next cycle.
- **Reset mid-operation.** A registered write-back in flight is dropped (`reg_wen`→0 immediately) and all pending bits clear.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-transfer → `reg_wen`=0 asynchronously; after release, ALU+LSU+MDU all valid → the ALU is granted first.
- **Round-robin fairness.** All three valid for 6 cycles with rd=1,2,3 → grant order ALU, LSU, MDU, ALU, LSU, MDU; `reg_wen`=1 every cycle, starting one cycle after the first grant.
- **Single requester streaming.** LSU only valid for 4 cycles, rd=5..8 with data 0xA0..0xA3 → `lsu_ready`=1 on every cycle; `rd`/`data_wb` show 5/0xA0 through 8/0xA3 on consecutive cycles.
- **Scoreboard RAW.** Issue rd=7 at cycle 0 → `rs1_busy`=1 with `rs1`=7; MDU writes rd=7 accepted at cycle 3 → `reg_wen`=1 at cycle 4, `rs1_busy`=0 at cycle 5.
- **WAW and x0.**
  - With x9 pending, `iss_rd`=9 → `iss_ready`=0.
  - `iss_rd`=0 → `iss_ready`=1 and no bit is set.
  - ALU write to rd=0 with data 0xFFFFFFFF → accepted, and `reg_wen` stays 0.
- **Simultaneous set/clear.** Write-back to x4 and a new issue to x4 at the same edge cannot coexist (issue stalls). Force an issue to x4 the cycle after the clear → `pending[4]`=1 again and `rs2_busy` (`rs2`=4) reads 1.
